// File: rtl/hazard_pkg.sv
// Shared parameters, register-file encodings and FSM state type for the
// issue-stage hazard scoreboard.
package hazard_pkg;
    localparam int NUM_REGS = 32;
    localparam int CNT_W    = 2;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int IDX_W    = 5;

    localparam logic RF_SCALAR = 1'b0;
    localparam logic RF_VECTOR = 1'b1;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/write-back/flush bundle between the pipeline and the hazard scoreboard.
interface hazard_scoreboard_if #(
    parameter int STALL_CNT_W = 16
);
    import hazard_pkg::*;

    logic                   issue_valid;
    logic                   issue_rf_sel;
    logic [IDX_W-1:0]       issue_rs1;
    logic [IDX_W-1:0]       issue_rs2;
    logic                   issue_use_rs2;
    logic [IDX_W-1:0]       issue_rd;
    logic                   issue_reg_write;
    logic                   wb_valid;
    logic                   wb_rf_sel;
    logic [IDX_W-1:0]       wb_rd;
    logic                   flush;
    logic                   stall_d;
    logic                   issue_fire;
    logic                   drain_busy;
    logic                   wb_underflow;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        output issue_valid, issue_rf_sel, issue_rs1, issue_rs2, issue_use_rs2,
               issue_rd, issue_reg_write, wb_valid, wb_rf_sel, wb_rd, flush,
        input  stall_d, issue_fire, drain_busy, wb_underflow, stall_cycles
    );

    modport slave (
        input  issue_valid, issue_rf_sel, issue_rs1, issue_rs2, issue_use_rs2,
               issue_rd, issue_reg_write, wb_valid, wb_rf_sel, wb_rd, flush,
        output stall_d, issue_fire, drain_busy, wb_underflow, stall_cycles
    );
endinterface

// File: rtl/scoreboard_bank.sv
// One register file's worth of pending-write counters with three read ports,
// an all-zero flag (post-update) and an underflow pulse.
module scoreboard_bank #(
    parameter int NUM_REGS  = hazard_pkg::NUM_REGS,
    parameter int CNT_W     = hazard_pkg::CNT_W,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          inc_en,
    input  logic [hazard_pkg::IDX_W-1:0]  inc_idx,
    input  logic                          dec_en,
    input  logic [hazard_pkg::IDX_W-1:0]  dec_idx,
    input  logic [hazard_pkg::IDX_W-1:0]  rd_idx1,
    input  logic [hazard_pkg::IDX_W-1:0]  rd_idx2,
    input  logic [hazard_pkg::IDX_W-1:0]  rd_idx3,
    output logic [CNT_W-1:0]              cnt1,
    output logic [CNT_W-1:0]              cnt2,
    output logic [CNT_W-1:0]              cnt3,
    output logic                          all_zero,
    output logic                          underflow
);
    import hazard_pkg::*;

    localparam logic [CNT_W-1:0] MAX_V = '1;

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] uf_vec;
    logic [NUM_REGS-1:0] nz_vec;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
            if (SKIP_ZERO && gi == 0) begin : g_fixed
                // Hard-wired register: never pending, never underflows.
                assign cnt_d[gi]  = '0;
                assign uf_vec[gi] = 1'b0;
            end else begin : g_track
                logic hit_inc;
                logic hit_dec;
                assign hit_inc = inc_en && (inc_idx == IDX_W'(gi));
                assign hit_dec = dec_en && (dec_idx == IDX_W'(gi));
                // A coinciding issue and retire cancel out.
                assign cnt_d[gi] =
                    (hit_inc && !hit_dec && cnt_q[gi] != MAX_V) ? cnt_q[gi] + 1'b1 :
                    (hit_dec && !hit_inc && cnt_q[gi] != '0)    ? cnt_q[gi] - 1'b1 :
                                                                  cnt_q[gi];
                assign uf_vec[gi] = hit_dec && (cnt_q[gi] == '0);
            end
            assign nz_vec[gi] = |cnt_d[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign cnt1      = cnt_q[rd_idx1];
    assign cnt2      = cnt_q[rd_idx2];
    assign cnt3      = cnt_q[rd_idx3];
    assign all_zero  = ~|nz_vec;
    assign underflow = |uf_vec;
endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage RAW/WAW-depth hazard scoreboard for split scalar/vector register
// files, with a flush-drain FSM and a saturating stall statistic.
module hazard_scoreboard #(
    parameter int NUM_REGS    = hazard_pkg::NUM_REGS,
    parameter int CNT_W       = hazard_pkg::CNT_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave bus
);
    import hazard_pkg::*;

    localparam logic [CNT_W-1:0] CNT_FULL = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e                 state_q, state_d;
    logic                   uf_q, uf_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [CNT_W-1:0] c_rs1 [2];
    logic [CNT_W-1:0] c_rs2 [2];
    logic [CNT_W-1:0] c_rd  [2];
    logic [1:0]       bank_zero;
    logic [1:0]       bank_uf;

    logic rs1_ready, rs2_ready, rd_full, hazard, fire_raw, stall_raw;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            scoreboard_bank #(
                .NUM_REGS (NUM_REGS),
                .CNT_W    (CNT_W),
                .SKIP_ZERO(gi == 0)
            ) u_bank (
                .clk      (clk),
                .rst      (rst),
                .inc_en   (fire_raw && bus.issue_reg_write && (bus.issue_rf_sel == 1'(gi))),
                .inc_idx  (bus.issue_rd),
                .dec_en   (bus.wb_valid && (bus.wb_rf_sel == 1'(gi))),
                .dec_idx  (bus.wb_rd),
                .rd_idx1  (bus.issue_rs1),
                .rd_idx2  (bus.issue_rs2),
                .rd_idx3  (bus.issue_rd),
                .cnt1     (c_rs1[gi]),
                .cnt2     (c_rs2[gi]),
                .cnt3     (c_rd[gi]),
                .all_zero (bank_zero[gi]),
                .underflow(bank_uf[gi])
            );
        end
    endgenerate

    // A last outstanding write retiring this very cycle satisfies a reader.
    always_comb begin
        rs1_ready = (c_rs1[bus.issue_rf_sel] == '0) ||
                    ((c_rs1[bus.issue_rf_sel] == CNT_ONE) && bus.wb_valid &&
                     (bus.wb_rf_sel == bus.issue_rf_sel) && (bus.wb_rd == bus.issue_rs1));
        rs2_ready = (c_rs2[bus.issue_rf_sel] == '0) ||
                    ((c_rs2[bus.issue_rf_sel] == CNT_ONE) && bus.wb_valid &&
                     (bus.wb_rf_sel == bus.issue_rf_sel) && (bus.wb_rd == bus.issue_rs2));
        rd_full   = (c_rd[bus.issue_rf_sel] == CNT_FULL);
        hazard    = !rs1_ready || (bus.issue_use_rs2 && !rs2_ready) ||
                    (bus.issue_reg_write && rd_full);
        fire_raw  = bus.issue_valid && !hazard && (state_q == RUN) && !bus.flush;
        stall_raw = bus.issue_valid && !fire_raw && !bus.flush;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.flush) state_d = DRAIN;
            DRAIN:   if (!bus.flush && (&bank_zero)) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        uf_d        = uf_q | (|bank_uf);
        stall_cnt_d = stall_cnt_q;
        if ((stall_raw || (bus.issue_valid && state_q == DRAIN)) && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            uf_q        <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            uf_q        <= uf_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // While reset is held the block presents a clean, hazard-free view.
    assign bus.issue_fire   = rst ? bus.issue_valid : fire_raw;
    assign bus.stall_d      = rst ? 1'b0 : stall_raw;
    assign bus.drain_busy   = !rst && (state_q == DRAIN);
    assign bus.wb_underflow = !rst && uf_q;
    assign bus.stall_cycles = rst ? '0 : stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: directed scenarios then random traffic, each cycle's
// expected outputs queued from a pending-write model and checked by a monitor.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.STALL_CNT_W(16)) bus();

    hazard_scoreboard #(
        .NUM_REGS   (32),
        .CNT_W      (2),
        .STALL_CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        bit rst, v, rf, use2, rw, wbv, wbrf, fl;
        int rs1, rs2, rd, wbrd;
    } stim_t;

    typedef struct {
        bit fire, stall, drain, uf;
        int sc;
        int id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   step_id = 0;

    // Model: number of not-yet-retired writes per (file, register).
    int pend[2][32];
    bit draining = 0;
    bit uf_m = 0;
    int sc_m = 0;

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.v = 0; s.rf = 0; s.use2 = 0; s.rw = 0; s.wbv = 0; s.wbrf = 0; s.fl = 0;
        s.rs1 = 0; s.rs2 = 0; s.rd = 0; s.wbrd = 0;
        return s;
    endfunction

    function automatic stim_t iss(bit rf, int rs1, bit use2, int rs2, bit rw, int rd);
        stim_t s = idle();
        s.v = 1; s.rf = rf; s.rs1 = rs1; s.use2 = use2; s.rs2 = rs2; s.rw = rw; s.rd = rd;
        return s;
    endfunction

    function automatic stim_t with_wb(stim_t s_in, bit rf, int rd);
        stim_t s = s_in;
        s.wbv = 1; s.wbrf = rf; s.wbrd = rd;
        return s;
    endfunction

    function automatic bit untracked(bit rf, int idx);
        return (rf == 0) && (idx == 0);
    endfunction

    function automatic bit src_ready(stim_t s, int idx);
        if (untracked(s.rf, idx)) return 1;
        if (pend[s.rf][idx] == 0) return 1;
        return (pend[s.rf][idx] == 1) && s.wbv && (s.wbrf == s.rf) && (s.wbrd == idx);
    endfunction

    task automatic step(stim_t s);
        exp_t e;
        bit   hz, inc, dec, all_zero;
        rst                 = s.rst;
        bus.issue_valid     = s.v;
        bus.issue_rf_sel    = s.rf;
        bus.issue_rs1       = 5'(s.rs1);
        bus.issue_rs2       = 5'(s.rs2);
        bus.issue_use_rs2   = s.use2;
        bus.issue_rd        = 5'(s.rd);
        bus.issue_reg_write = s.rw;
        bus.wb_valid        = s.wbv;
        bus.wb_rf_sel       = s.wbrf;
        bus.wb_rd           = 5'(s.wbrd);
        bus.flush           = s.fl;

        hz = !src_ready(s, s.rs1) || (s.use2 && !src_ready(s, s.rs2)) ||
             (s.rw && !untracked(s.rf, s.rd) && pend[s.rf][s.rd] == 3);
        e.id = step_id;
        if (s.rst) begin
            e.fire = s.v; e.stall = 0; e.drain = 0; e.uf = 0; e.sc = 0;
        end else begin
            e.fire  = s.v && !hz && !draining && !s.fl;
            e.stall = s.v && !e.fire && !s.fl;
            e.drain = draining; e.uf = uf_m; e.sc = sc_m;
        end
        exp_q.push_back(e);

        // Advance the model across the clock edge.
        if (s.rst) begin
            foreach (pend[f, r]) pend[f][r] = 0;
            draining = 0; uf_m = 0; sc_m = 0;
        end else begin
            inc = e.fire && s.rw && !untracked(s.rf, s.rd);
            dec = s.wbv && !untracked(s.wbrf, s.wbrd);
            if (dec && pend[s.wbrf][s.wbrd] == 0) uf_m = 1;
            if (inc && dec && s.rf == s.wbrf && s.rd == s.wbrd) begin
                // cancel: net zero
            end else begin
                if (dec && pend[s.wbrf][s.wbrd] > 0) pend[s.wbrf][s.wbrd]--;
                if (inc) pend[s.rf][s.rd]++;
            end
            if ((e.stall || (s.v && draining)) && sc_m < 65535) sc_m++;
            all_zero = 1;
            foreach (pend[f, r]) if (pend[f][r] != 0) all_zero = 0;
            if (!draining) draining = s.fl;
            else if (!s.fl && all_zero) draining = 0;
        end
        step_id++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, int id, int act, int exp_v);
        checks++;
        if (act == exp_v) passes++;
        else $display("FAIL %s step %0d: got %0d required %0d", name, id, act, exp_v);
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("issue_fire",   e.id, int'(bus.issue_fire),   int'(e.fire));
                chk("stall_d",      e.id, int'(bus.stall_d),      int'(e.stall));
                chk("drain_busy",   e.id, int'(bus.drain_busy),   int'(e.drain));
                chk("wb_underflow", e.id, int'(bus.wb_underflow), int'(e.uf));
                chk("stall_cycles", e.id, int'(bus.stall_cycles), e.sc);
                $display("step %0d fire=%0b stall=%0b drain=%0b uf=%0b sc=%0d",
                         e.id, bus.issue_fire, bus.stall_d, bus.drain_busy,
                         bus.wb_underflow, bus.stall_cycles);
            end
        end
    end

    initial begin
        stim_t s;
        int    pf[$];
        int    pi[$];
        int    k;
        foreach (pend[f, r]) pend[f][r] = 0;
        @(posedge clk);
        #1;

        // Reset, with an instruction presented during reset.
        s = idle(); s.rst = 1; step(s);
        s = iss(0, 5, 1, 6, 1, 7); s.rst = 1; step(s);
        step(idle());

        // RAW on x5 with write-back bypass.
        step(iss(0, 0, 0, 0, 1, 5));
        step(iss(0, 5, 0, 0, 0, 0));
        step(iss(0, 5, 0, 0, 0, 0));
        step(with_wb(iss(0, 5, 0, 0, 0, 0), 0, 5));
        step(iss(0, 5, 1, 5, 0, 0));

        // File separation: pending v5 does not block x5.
        step(iss(1, 0, 0, 0, 1, 5));
        step(iss(0, 5, 1, 5, 0, 0));
        step(iss(1, 5, 0, 0, 0, 0));
        step(with_wb(idle(), 1, 5));
        step(iss(1, 5, 0, 0, 0, 0));

        // x0 immunity.
        step(iss(0, 0, 0, 0, 1, 0));
        step(iss(0, 0, 1, 0, 0, 0));
        step(with_wb(idle(), 0, 0));
        step(idle());

        // Saturation of v3 and issue/write-back collision.
        for (int i = 0; i < 4; i++) step(iss(1, 1, 0, 0, 1, 3));
        step(with_wb(iss(1, 1, 0, 0, 1, 3), 1, 3));
        step(with_wb(iss(1, 1, 0, 0, 1, 3), 1, 3));
        step(iss(1, 1, 0, 0, 1, 3));
        step(iss(1, 1, 0, 0, 1, 3));
        for (int i = 0; i < 3; i++) step(with_wb(idle(), 1, 3));

        // Flush drain with two outstanding writes.
        step(iss(0, 0, 0, 0, 1, 1));
        s = iss(0, 0, 0, 0, 1, 2); step(s);
        s = iss(0, 3, 0, 0, 0, 0); s.fl = 1; step(s);
        step(iss(0, 3, 0, 0, 0, 0));
        step(with_wb(iss(0, 3, 0, 0, 0, 0), 0, 1));
        step(iss(0, 3, 0, 0, 0, 0));
        step(with_wb(iss(0, 3, 0, 0, 0, 0), 0, 2));
        step(iss(0, 3, 0, 0, 1, 4));
        step(with_wb(idle(), 0, 4));

        // Reset in the middle of a drain, then a spurious write-back.
        step(iss(0, 0, 0, 0, 1, 7));
        step(iss(1, 0, 0, 0, 1, 7));
        s = idle(); s.fl = 1; step(s);
        step(iss(0, 7, 0, 0, 0, 0));
        s = iss(0, 7, 0, 0, 0, 0); s.rst = 1; step(s);
        step(iss(1, 7, 0, 0, 0, 0));
        step(with_wb(idle(), 0, 9));
        step(idle());
        s = idle(); s.rst = 1; step(s);

        // Random traffic on a small register window to provoke hazards.
        for (int n = 0; n < 2000; n++) begin
            s = idle();
            s.v    = ($urandom_range(0, 9) < 7);
            s.rf   = 1'($urandom_range(0, 1));
            s.rs1  = $urandom_range(0, 3);
            s.rs2  = $urandom_range(0, 3);
            s.use2 = 1'($urandom_range(0, 1));
            s.rw   = 1'($urandom_range(0, 1));
            s.rd   = $urandom_range(0, 3);
            s.fl   = ($urandom_range(0, 19) == 0);
            s.rst  = ($urandom_range(0, 199) == 0);
            pf.delete(); pi.delete();
            foreach (pend[f, r]) if (pend[f][r] > 0) begin pf.push_back(f); pi.push_back(r); end
            if (pf.size() > 0 && $urandom_range(0, 9) < 5) begin
                k = $urandom_range(0, pf.size() - 1);
                s = with_wb(s, 1'(pf[k]), pi[k]);
            end else if ($urandom_range(0, 99) == 0) begin
                s = with_wb(s, 1'($urandom_range(0, 1)), $urandom_range(0, 31));
            end
            step(s);
        end
        step(idle());

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL queue_drained: got %0d pending required 0", exp_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
